// File: rtl/byte_inc_job_sched.sv
// Round-robin job scheduler sharing one byte_inc engine between REQ_CNT requesters.
// Optional watchdog on WAIT_DONE enabled by macro BYTE_INC_SCHED_WDOG_EN.
module byte_inc_job_sched #(
  parameter int REQ_CNT    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic [REQ_CNT-1:0]            req_valid_i,
  output logic [REQ_CNT-1:0]            req_ready_o,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0] req_base_addr_i,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0] req_length_i,
  output logic [REQ_CNT-1:0]            done_o,
  output logic [REQ_CNT-1:0]            err_o,
  output logic                          busy_o,
  output logic                          eng_run_o,
  output logic [ADDR_WIDTH-1:0]         eng_base_addr_o,
  output logic [ADDR_WIDTH-1:0]         eng_length_o,
  input  logic                          eng_waitrequest_i
);

  localparam int PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int BW_W  = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  state_t                               state_q, state_d;
  logic [REQ_CNT-1:0]                   slot_full_q, slot_full_d;
  logic [REQ_CNT-1:0][ADDR_WIDTH-1:0]   slot_base_q, slot_base_d;
  logic [REQ_CNT-1:0][ADDR_WIDTH-1:0]   slot_len_q, slot_len_d;
  logic [PTR_W-1:0]                     ptr_q, ptr_d;
  logic [PTR_W-1:0]                     grant_q, grant_d;
  logic [BW_W-1:0]                      bw_cnt_q, bw_cnt_d;
  logic [REQ_CNT-1:0]                   done_q, done_d;
  logic                                 busy_q, busy_d;
  logic                                 run_q, run_d;
  logic [ADDR_WIDTH-1:0]                eng_base_q, eng_base_d;
  logic [ADDR_WIDTH-1:0]                eng_len_q, eng_len_d;
  logic                                 arb_found_s;
  logic [PTR_W-1:0]                     arb_idx_s;
  logic [PTR_W-1:0]                     arb_next_s;
`ifdef BYTE_INC_SCHED_WDOG_EN
  logic [15:0]                          wd_cnt_q, wd_cnt_d;
  logic [REQ_CNT-1:0]                   err_q, err_d;
`endif

  // Round-robin search over registered full slots, starting at the pointer.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    idx_v       = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      idx_v = PTR_W'((int'(ptr_q) + k) % REQ_CNT);
      if (!arb_found_s && slot_full_q[idx_v]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = idx_v;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
    arb_next_s = PTR_W'((int'(arb_idx_s) + 1) % REQ_CNT);
  end

  // Slot capture, job FSM next state and registered output values.
  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_base_d = slot_base_q;
    slot_len_d  = slot_len_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    bw_cnt_d    = bw_cnt_q;
    eng_base_d  = eng_base_q;
    eng_len_d   = eng_len_q;
    done_d      = '0;
`ifdef BYTE_INC_SCHED_WDOG_EN
    wd_cnt_d    = 16'h0000;
    err_d       = '0;
`endif

    for (int i = 0; i < REQ_CNT; i++) begin
      if (req_valid_i[i] && !slot_full_q[i]) begin
        slot_full_d[i] = 1'b1;
        slot_base_d[i] = req_base_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        slot_len_d[i]  = req_length_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        slot_full_d[i] = slot_full_d[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          grant_d = arb_idx_s;
          ptr_d   = arb_next_s;
          // Zero-length jobs complete without touching the engine.
          if (slot_len_q[arb_idx_s] == '0) begin
            state_d = ST_DONE;
          end else begin
            eng_base_d = slot_base_q[arb_idx_s];
            eng_len_d  = slot_len_q[arb_idx_s];
            state_d    = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!eng_waitrequest_i) begin
          state_d  = ST_WAIT_BUSY;
          bw_cnt_d = '0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_BUSY: begin
        // An engine that never raises waitrequest is treated as finished.
        if (eng_waitrequest_i) begin
          state_d = ST_WAIT_DONE;
        end else if (bw_cnt_q == BW_W'(BUSY_WAIT - 1)) begin
          state_d = ST_DONE;
        end else begin
          bw_cnt_d = bw_cnt_q + BW_W'(1);
        end
      end
      ST_WAIT_DONE: begin
`ifdef BYTE_INC_SCHED_WDOG_EN
        if (!eng_waitrequest_i) begin
          state_d = ST_DONE;
        end else if (wd_cnt_q == 16'hFFFF) begin
          state_d = ST_ERR;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'h0001;
        end
`else
        if (!eng_waitrequest_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
`endif
      end
      ST_DONE, ST_ERR: begin
        slot_full_d[grant_q] = 1'b0;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_d  = (state_d == ST_ISSUE);
    busy_d = (state_d != ST_IDLE);
    done_d[grant_d] = (state_d == ST_DONE);
`ifdef BYTE_INC_SCHED_WDOG_EN
    err_d[grant_d]  = (state_d == ST_ERR);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= ST_IDLE;
      slot_full_q <= '0;
      slot_base_q <= '0;
      slot_len_q  <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      bw_cnt_q    <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      run_q       <= 1'b0;
      eng_base_q  <= '0;
      eng_len_q   <= '0;
`ifdef BYTE_INC_SCHED_WDOG_EN
      wd_cnt_q    <= 16'h0000;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      slot_base_q <= slot_base_d;
      slot_len_q  <= slot_len_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      bw_cnt_q    <= bw_cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      run_q       <= run_d;
      eng_base_q  <= eng_base_d;
      eng_len_q   <= eng_len_d;
`ifdef BYTE_INC_SCHED_WDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready_o     = ~slot_full_q;
  assign done_o          = done_q;
  assign busy_o          = busy_q;
  assign eng_run_o       = run_q;
  assign eng_base_addr_o = eng_base_q;
  assign eng_length_o    = eng_len_q;
`ifdef BYTE_INC_SCHED_WDOG_EN
  assign err_o           = err_q;
`else
  assign err_o           = '0;
`endif

endmodule
